// File: rtl/harris_corner_nms_pkg.sv
// Shared types and helpers for the Harris corner back end.
package harris_corner_nms_pkg;
    localparam int SCORE_W_DEF = 32;
    localparam int CNT_W       = 16;

    // Flags carried by the stage-1 register alongside the candidate record.
    typedef struct packed {
        logic cand;
        logic last;
    } s1_flags_t;

    function automatic int coord_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/harris_corner_nms_if.sv
// Corner record stream: valid/ready handshake carrying (x, y, score).
interface harris_corner_nms_if #(
    parameter int XW      = 6,
    parameter int YW      = 6,
    parameter int SCORE_W = 32
);
    logic                      valid;
    logic                      ready;
    logic [XW-1:0]             x;
    logic [YW-1:0]             y;
    logic signed [SCORE_W-1:0] score;

    modport master (output valid, x, y, score, input ready);
    modport slave  (input valid, x, y, score, output ready);
endinterface

// File: rtl/harris_corner_fifo.sv
// First-word-fall-through FIFO for corner records; same-cycle push and pop allowed when full.
module harris_corner_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] rdata,
    output logic          accepted
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wp, rp;
    logic          empty, full, pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wp == rp);
    assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop      = !empty && ready;
    assign accepted = push && (!full || pop);
    assign valid    = !empty;
    assign rdata    = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk)
        if (accepted) mem[wp[AW-1:0]] <= wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (accepted) wp <= wp + (AW+1)'(1);
            if (pop)      rp <= rp + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/harris_corner_nms.sv
// Harris back end: threshold plus optional 3x3 non-maximum suppression, corner FIFO, frame stats.
module harris_corner_nms
    import harris_corner_nms_pkg::*;
#(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 48,
    parameter int SCORE_W    = SCORE_W_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int NMS_EN     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [SCORE_W-1:0] score_in,
    input  logic                      score_valid,
    input  logic                      sof,
    input  logic signed [SCORE_W-1:0] threshold,
    harris_corner_nms_if.master       cif,
    output logic [CNT_W-1:0]          frame_corners,
    output logic                      frame_done,
    output logic                      overflow
);
    localparam int XW = coord_w(IMG_W);
    localparam int YW = coord_w(IMG_H);

    typedef logic signed [SCORE_W-1:0] score_t;
    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        score_t        score;
    } corner_t;

    logic [XW-1:0] xi, px;
    logic [YW-1:0] yi, py;
    logic          row_end, frm_end;

    // sof re-anchors the accepted pixel to (0,0) whatever the counters say.
    assign px      = sof ? '0 : xi;
    assign py      = sof ? '0 : yi;
    assign row_end = (px == XW'(IMG_W-1));
    assign frm_end = row_end && (py == YW'(IMG_H-1));

    score_t lb1 [IMG_W];
    score_t lb2 [IMG_W];
    score_t wt [2], wm [2], wb [2];
    score_t nt, nm, nb, ctr;

    assign nt  = lb2[px];
    assign nm  = lb1[px];
    assign nb  = score_in;
    assign ctr = wm[1];

    always_ff @(posedge clk)
        if (score_valid) begin
            lb2[px] <= lb1[px];
            lb1[px] <= score_in;
        end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xi <= '0;
            yi <= '0;
            for (int i = 0; i < 2; i++) begin
                wt[i] <= '0;
                wm[i] <= '0;
                wb[i] <= '0;
            end
        end else if (score_valid) begin
            xi <= row_end ? '0 : px + XW'(1);
            if (row_end) yi <= (py == YW'(IMG_H-1)) ? '0 : py + YW'(1);
            else         yi <= py;
            wt[0] <= wt[1]; wm[0] <= wm[1]; wb[0] <= wb[1];
            wt[1] <= nt;    wm[1] <= nm;    wb[1] <= nb;
        end
    end

    logic    nms_hit, cand;
    corner_t rec;

    // Ties go to the earliest pixel in raster order: strict against earlier, >= against later.
    always_comb begin
        nms_hit = (px >= XW'(2)) && (py >= YW'(2)) && (ctr > threshold)
               && (ctr > wt[0]) && (ctr > wt[1]) && (ctr > nt) && (ctr > wm[0])
               && (ctr >= nm) && (ctr >= wb[0]) && (ctr >= wb[1]) && (ctr >= nb);
        if (NMS_EN != 0) begin
            cand = nms_hit;
            rec  = '{x: px - XW'(1), y: py - YW'(1), score: ctr};
        end else begin
            cand = (score_in > threshold);
            rec  = '{x: px, y: py, score: score_in};
        end
    end

    s1_flags_t s1_f;
    corner_t   s1_rec, head;
    logic      fifo_wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_f   <= '0;
            s1_rec <= '0;
        end else begin
            s1_f   <= '{cand: score_valid && cand, last: score_valid && frm_end};
            s1_rec <= rec;
        end
    end

    harris_corner_fifo #(.DW($bits(corner_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (s1_f.cand),
        .wdata    (s1_rec),
        .ready    (cif.ready),
        .valid    (cif.valid),
        .rdata    (head),
        .accepted (fifo_wr)
    );

    assign cif.x     = head.x;
    assign cif.y     = head.y;
    assign cif.score = head.score;

    logic [CNT_W-1:0] run_cnt, cnt_nxt;

    assign cnt_nxt = (fifo_wr && run_cnt != '1) ? run_cnt + CNT_W'(1) : run_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt       <= '0;
            frame_corners <= '0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            frame_done <= s1_f.last;
            run_cnt    <= (s1_f.last || (score_valid && sof)) ? '0 : cnt_nxt;
            if (s1_f.last) frame_corners <= cnt_nxt;
            if (s1_f.cand && !fifo_wr)     overflow <= 1'b1;
            else if (score_valid && sof)   overflow <= 1'b0;
        end
    end
endmodule
